// File: rtl/cocofdc_sram_arbiter.sv
// NCH-channel arbiter: async request strobes are synchronised, queued and served as timed SRAM accesses.
// Define COCOFDC_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, highest index wins.
module cocofdc_sram_arbiter #(
  parameter int NCH  = 3,
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int ACC  = 4,
  parameter int SYNC = 3
) (
  input  logic              clock_50,
  input  logic              reset_n,
  input  logic [NCH-1:0]    ch_stb_n,
  input  logic [NCH-1:0]    ch_rw,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH*DW-1:0] ch_rdata,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_ovf,
  input  logic [NCH-1:0]    ovf_clr,
  output logic [AW-1:0]     sram_addrbus,
  inout  wire  [DW-1:0]     sram_databus,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n,
  output logic              busy
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t          state_reg;
  logic [2:0]      cnt_reg;
  logic [IW-1:0]   idx_reg;
  logic            rw_reg;
  logic            drive_reg;
  logic [DW-1:0]   wdata_reg;
  logic [NCH-1:0]  pend_reg;
  logic [DW-1:0]   rdata_reg [NCH];
  logic [SYNC-1:0] sync_reg [NCH];
  logic [NCH-1:0]  fall;
  logic [NCH-1:0]  grant;
  logic [IW-1:0]   sel;
  logic            any_pend;
`ifdef COCOFDC_ARB_RR_EN
  logic [IW-1:0]   ptr_reg;
`endif

  assign sram_ce_n    = 1'b0;
  assign sram_databus = drive_reg ? wdata_reg : {DW{1'bz}};
  assign any_pend     = |pend_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      // oldest synchronised sample still high while the next one is low = falling edge
      assign fall[gi] = sync_reg[gi][SYNC-1] & ~sync_reg[gi][SYNC-2];
      assign ch_rdata[gi*DW +: DW] = rdata_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) sync_reg[IW'(i)] <= '1;
    end else begin
      for (int i = 0; i < NCH; i++)
        sync_reg[IW'(i)] <= {sync_reg[IW'(i)][SYNC-2:0], ch_stb_n[IW'(i)]};
    end
  end

  always_comb begin
    sel = '0;
`ifdef COCOFDC_ARB_RR_EN
    // scan downwards so the candidate closest to ptr+1 is assigned last and wins
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend_reg[IW'((int'(ptr_reg) + 1 + k) % NCH)])
        sel = IW'((int'(ptr_reg) + 1 + k) % NCH);
    end
`else
    for (int i = 0; i < NCH; i++) begin
      if (pend_reg[IW'(i)]) sel = IW'(i);
    end
`endif
  end

  always_comb begin
    grant = '0;
    if (state_reg == IDLE && any_pend) grant[sel] = 1'b1;
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      rw_reg       <= 1'b0;
      drive_reg    <= 1'b0;
      wdata_reg    <= '0;
      pend_reg     <= '0;
      ch_ovf       <= '0;
      ch_done      <= '0;
      sram_addrbus <= '0;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      busy         <= 1'b0;
      for (int i = 0; i < NCH; i++) rdata_reg[IW'(i)] <= '0;
`ifdef COCOFDC_ARB_RR_EN
      ptr_reg      <= IW'(NCH - 1);
`endif
    end else begin
      // a new edge on the channel being granted re-arms it rather than overflowing
      pend_reg <= (pend_reg & ~grant) | fall;
      ch_ovf   <= (ch_ovf & ~ovf_clr) | (fall & pend_reg & ~grant);
      ch_done  <= '0;
      case (state_reg)
        IDLE: begin
          if (any_pend) begin
            idx_reg      <= sel;
            rw_reg       <= ch_rw[sel];
            sram_addrbus <= ch_addr[int'(sel)*AW +: AW];
            wdata_reg    <= ch_wdata[int'(sel)*DW +: DW];
            cnt_reg      <= 3'(ACC);
            busy         <= 1'b1;
            sram_oe_n    <= ~ch_rw[sel];
            sram_we_n    <= ch_rw[sel];
            drive_reg    <= ~ch_rw[sel];
            state_reg    <= ACCESS;
`ifdef COCOFDC_ARB_RR_EN
            ptr_reg      <= sel;
`endif
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            if (rw_reg) rdata_reg[idx_reg] <= sram_databus;
            sram_we_n        <= 1'b1;
            sram_oe_n        <= 1'b1;
            drive_reg        <= 1'b0;
            ch_done[idx_reg] <= 1'b1;
            state_reg        <= RECOVER;
          end
        end
        RECOVER: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cocofdc_sram_arbiter.sv
// Bench for cocofdc_sram_arbiter: rounds of channel requests checked against an SRAM model plus
// an arbitration-order/memory reference model; directed overflow, grant-tick and reset cases.
`timescale 1ns/1ps
module tb_cocofdc_sram_arbiter;
  localparam int NCH = 3, AW = 16, DW = 8, ACC = 4, SYNC = 3, IW = 2;

  logic              clock_50 = 1'b0;
  logic              reset_n  = 1'b0;
  logic [NCH-1:0]    ch_stb_n = '1;
  logic [NCH-1:0]    ch_rw    = '0;
  logic [NCH-1:0]    ovf_clr  = '0;
  logic [NCH*AW-1:0] ch_addr  = '0;
  logic [NCH*DW-1:0] ch_wdata = '0;
  wire  [NCH*DW-1:0] ch_rdata;
  wire  [NCH-1:0]    ch_done, ch_ovf;
  wire  [AW-1:0]     sram_addrbus;
  wire  [DW-1:0]     sram_databus;
  wire               sram_we_n, sram_oe_n, sram_ce_n, busy;

  cocofdc_sram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .ACC(ACC), .SYNC(SYNC)) dut (
    .clock_50(clock_50), .reset_n(reset_n), .ch_stb_n(ch_stb_n), .ch_rw(ch_rw),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_done(ch_done),
    .ch_ovf(ch_ovf), .ovf_clr(ovf_clr), .sram_addrbus(sram_addrbus),
    .sram_databus(sram_databus), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n), .busy(busy));

  always #10 clock_50 = ~clock_50;

  // SRAM model: unwritten locations read back a fixed address-derived pattern
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  bit   [7:0]    sram_mem [65536];
  bit            sram_wr  [65536];
  logic [DW-1:0] sram_rd;
  assign sram_rd      = sram_wr[sram_addrbus] ? sram_mem[sram_addrbus] : init_val(sram_addrbus);
  assign sram_databus = (!sram_oe_n && sram_we_n && !sram_ce_n) ? sram_rd : 8'bz;

  typedef struct {
    int            ch;
    int            tick;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
    int            len;
  } acc_t;

  acc_t log_q[$];
  int   exp_q[$];
  int   n_checks = 0, n_fail = 0, viol = 0, tick_cnt = 0;

  logic [7:0]    ref_mem [65536];
  bit            ref_wr  [65536];
  logic [DW-1:0] ref_rdata [NCH];
  logic          t_rw    [NCH];
  logic [AW-1:0] t_addr  [NCH];
  logic [DW-1:0] t_wdata [NCH];
  int            rr_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic bus_driven();
    return (sram_databus !== 8'bz) && (sram_databus !== 8'h00);
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  // bus monitor: one record per completed access, protocol violations counted
  initial begin
    acc_t cur;
    logic act, prev_act, prev_done;
    cur = '{0, 0, '0, 1'b0, '0, 0};
    prev_act = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clock_50);
      tick_cnt++;
      act = !sram_we_n || !sram_oe_n;
      if (!sram_we_n && !sram_oe_n) viol++;
      if (sram_we_n && sram_oe_n && bus_driven()) viol++;
      if (act && !busy) viol++;
      if (act && !prev_act) begin
        cur.tick = tick_cnt;
        cur.addr = sram_addrbus;
        cur.we   = !sram_we_n;
        cur.data = sram_databus;
        cur.len  = 0;
      end
      if (act) begin
        cur.len++;
        if (sram_addrbus !== cur.addr || cur.we !== !sram_we_n) viol++;
        if (!sram_we_n) begin
          if (sram_databus !== cur.data) viol++;
          sram_mem[sram_addrbus] = sram_databus;
          sram_wr[sram_addrbus]  = 1'b1;
        end
      end
      if (ch_done != '0) begin
        if ($countones(ch_done) != 1 || prev_done || !busy) viol++;
        for (int c = 0; c < NCH; c++) if (ch_done[IW'(c)]) cur.ch = c;
        if (!cur.we) cur.data = ch_rdata[cur.ch*DW +: DW];
        log_q.push_back(cur);
      end
      prev_act  = act;
      prev_done = (ch_done != '0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic drive_fields();
    for (int c = 0; c < NCH; c++) begin
      ch_rw[IW'(c)]          = t_rw[IW'(c)];
      ch_addr[c*AW +: AW]    = t_addr[IW'(c)];
      ch_wdata[c*DW +: DW]   = t_wdata[IW'(c)];
    end
  endtask

  task automatic wait_acc(input int n);
    for (int t = 0; t < 400 && log_q.size() < n; t++) tick(1);
    tick(4);
  endtask

  task automatic check_log();
    int n, c;
    logic [7:0] e;
    check("acc_count", log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      c = exp_q[i];
      check("grant_ch", log_q[i].ch, c);
      check("addr", 32'(log_q[i].addr), 32'(t_addr[IW'(c)]));
      check("is_write", 32'(log_q[i].we), 32'(!t_rw[IW'(c)]));
      check("strobe_len", log_q[i].len, ACC);
      if (i > 0) check("grant_gap", log_q[i].tick - log_q[i-1].tick, ACC + 2);
      if (!t_rw[IW'(c)]) begin
        check("wdata", 32'(log_q[i].data), 32'(t_wdata[IW'(c)]));
        ref_mem[t_addr[IW'(c)]] = t_wdata[IW'(c)];
        ref_wr[t_addr[IW'(c)]]  = 1'b1;
      end else begin
        e = ref_read(t_addr[IW'(c)]);
        check("rdata", 32'(log_q[i].data), 32'(e));
        ref_rdata[IW'(c)] = e;
      end
    end
    if (exp_q.size() > 0) rr_ptr = exp_q[exp_q.size()-1];
    for (int k = 0; k < NCH; k++)
      check("rdata_hold", 32'(ch_rdata[k*DW +: DW]), 32'(ref_rdata[IW'(k)]));
  endtask

  // all strobes in mask fall together; expected service order comes from the arbitration rule
  task automatic run_round(input logic [NCH-1:0] mask);
    exp_q.delete();
`ifdef COCOFDC_ARB_RR_EN
    for (int k = 1; k <= NCH; k++)
      if (mask[IW'((rr_ptr + k) % NCH)]) exp_q.push_back((rr_ptr + k) % NCH);
`else
    for (int c = NCH - 1; c >= 0; c--)
      if (mask[IW'(c)]) exp_q.push_back(c);
`endif
    drive_fields();
    log_q.delete();
    ch_stb_n = ~mask;
    wait_acc(exp_q.size());
    ch_stb_n = '1;
    tick(SYNC + 3);
    check_log();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_ptr = NCH - 1;
    for (int c = 0; c < NCH; c++) begin
      ref_rdata[IW'(c)] = '0;
      t_rw[IW'(c)]      = 1'b1;
      t_addr[IW'(c)]    = '0;
      t_wdata[IW'(c)]   = '0;
    end
    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_we_n", 32'(sram_we_n), 1);
    check("rst_oe_n", 32'(sram_oe_n), 1);
    check("rst_ce_n", 32'(sram_ce_n), 0);
    check("rst_addr", 32'(sram_addrbus), 0);
    check("rst_done", 32'(ch_done), 0);
    check("rst_ovf", 32'(ch_ovf), 0);
    check("rst_rdata", 32'(ch_rdata), 0);
    check("rst_bus_float", 32'(bus_driven()), 0);
    reset_n = 1'b1;
    tick(3);

    // single read of a location preloaded through channel 2
    t_rw[2] = 1'b0; t_addr[2] = 16'h2000; t_wdata[2] = 8'h5A;
    run_round(3'b100);
    t_rw[0] = 1'b1; t_addr[0] = 16'h2000;
    run_round(3'b001);
    check("single_read", 32'(ch_rdata[7:0]), 32'h5A);

    // write then read on different channels
    t_rw[2] = 1'b0; t_addr[2] = 16'h0011; t_wdata[2] = 8'hC3;
    run_round(3'b100);
    t_rw[1] = 1'b1; t_addr[1] = 16'h0011;
    run_round(3'b010);
    check("wr_then_rd", 32'(ch_rdata[15:8]), 32'hC3);

    // simultaneous strobes after channel 0 was the last grant
    t_rw[0] = 1'b1; t_addr[0] = 16'h0030;
    t_rw[1] = 1'b1; t_addr[1] = 16'h2000;
    t_rw[2] = 1'b1; t_addr[2] = 16'h0011;
    run_round(3'b001);
    run_round(3'b111);

    // overflow: ch0 falls twice while ch2 owns the bus
    t_rw[2] = 1'b1; t_addr[2] = 16'h0003;
    t_rw[0] = 1'b1; t_addr[0] = 16'h0004;
    drive_fields();
    exp_q = '{2, 0};
    log_q.delete();
    ch_stb_n = 3'b011; tick(1);
    ch_stb_n = 3'b010; tick(2);
    ch_stb_n = 3'b011; tick(2);
    ch_stb_n = 3'b010;
    wait_acc(2);
    ch_stb_n = '1;
    tick(SYNC + 3);
    check_log();
    check("ovf_set", 32'(ch_ovf), 32'b001);
    ovf_clr = 3'b001; tick(1);
    ovf_clr = 3'b000;
    check("ovf_clr", 32'(ch_ovf), 0);

    // ch1 re-strobes so that its second edge lands on its own grant tick
    t_rw[2] = 1'b1; t_addr[2] = 16'h0006;
    t_rw[1] = 1'b1; t_addr[1] = 16'h0007;
    drive_fields();
    exp_q = '{2, 1, 1};
    log_q.delete();
    ch_stb_n = 3'b011; tick(2);
    ch_stb_n = 3'b001; tick(3);
    ch_stb_n = 3'b011; tick(2);
    ch_stb_n = 3'b001;
    wait_acc(3);
    ch_stb_n = '1;
    tick(SYNC + 3);
    check_log();
    check("ovf_grant_tick", 32'(ch_ovf), 0);

    // reset during the second tick of a write, with ch0 left pending
    t_rw[2] = 1'b0; t_addr[2] = 16'hFFFF; t_wdata[2] = 8'h77;
    t_rw[0] = 1'b1; t_addr[0] = 16'h0005;
    drive_fields();
    log_q.delete();
    ch_stb_n = 3'b010;
    for (int t = 0; t < 40 && sram_we_n; t++) tick(1);
    check("rst_write_started", 32'(sram_we_n), 0);
    tick(1);
    #3 reset_n = 1'b0;
    #1;
    check("async_we_n", 32'(sram_we_n), 1);
    check("async_oe_n", 32'(sram_oe_n), 1);
    check("async_busy", 32'(busy), 0);
    ch_stb_n = '1;
    tick(4);
    reset_n = 1'b1;
    rr_ptr = NCH - 1;
    for (int c = 0; c < NCH; c++) ref_rdata[IW'(c)] = '0;
    tick(25);
    check("rst_no_access", log_q.size(), 0);
    check("rst_idle_busy", 32'(busy), 0);
    check("rst_bus_float2", 32'(bus_driven()), 0);
    t_rw[0] = 1'b1; t_addr[0] = 16'h0011;
    run_round(3'b001);

    // randomized rounds over a small address window so writes and reads collide
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < NCH; c++) begin
        t_rw[IW'(c)]    = 1'($urandom_range(0, 1));
        t_addr[IW'(c)]  = 16'($urandom_range(0, 31));
        t_wdata[IW'(c)] = 8'($urandom);
      end
      run_round(3'($urandom_range(1, 7)));
    end

    check("bus_protocol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
